// File: rtl/load_reg_arbiter_if.sv
// Bus between the load-register arbiter, its requesting clients and the shared load register.
// The master side is the arbiter. The slave side is the clients together with the register.
interface load_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           load;
  logic [W-1:0]   I;
  logic [W-1:0]   A;
  logic [N-1:0]   ack;
  logic [N-1:0]   nak;
  logic           busy;
  logic           err;

  modport master (
    input  req, data, A,
    output load, I, ack, nak, busy, err
  );

  modport slave (
    output req, data, A,
    input  load, I, ack, nak, busy, err
  );
endinterface

// File: rtl/load_reg_arbiter.sv
// Round-robin arbiter that loads one requester's word into the shared register.
// It reads the word back and answers with ack when it matches, or nak after the retries run out.
module load_reg_arbiter #(
  parameter int N         = 4,
  parameter int W         = 4,
  parameter int MAX_RETRY = 2
) (
  input logic                clk,
  input logic                rst,
  load_reg_arbiter_if.master bus
);
  localparam int         PW          = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t         state, state_n;
  logic [PW-1:0]  ptr, ptr_n;
  logic [PW-1:0]  win, win_n;
  logic [PW-1:0]  pick, win_inc;
  logic [W-1:0]   held, held_n;
  logic [2:0]     retry, retry_n;
  logic           err, err_n;
  logic           found;
  logic [N-1:0]   ack_c, nak_c;

  // The first set request at or after ptr wins, wrapping around past N-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % N]) begin
        pick  = PW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

  assign win_inc = (win == PW'(N - 1)) ? '0 : win + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      held  <= '0;
      retry <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      win   <= win_n;
      held  <= held_n;
      retry <= retry_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    held_n  = held;
    retry_n = retry;
    err_n   = err;
    ack_c   = '0;
    nak_c   = '0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          win_n   = pick;
          held_n  = bus.data[int'(pick)*W +: W];
          retry_n = '0;
          state_n = LOAD;
        end
      end
      LOAD: state_n = CHECK;
      CHECK: begin
        if (bus.A == held) begin
          ack_c[win] = 1'b1;
          ptr_n      = win_inc;
          state_n    = IDLE;
        end else if (retry < RETRY_LIMIT) begin
          retry_n = retry + 3'd1;
          state_n = LOAD;
        end else begin
          nak_c[win] = 1'b1;
          err_n      = 1'b1;
          ptr_n      = win_inc;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A reset that lands in the CHECK cycle suppresses the response that would otherwise pulse.
  assign bus.ack  = rst ? '0 : ack_c;
  assign bus.nak  = rst ? '0 : nak_c;
  assign bus.load = (state == LOAD);
  assign bus.I    = (state == LOAD) ? held : '0;
  assign bus.busy = (state != IDLE);
  assign bus.err  = err;
endmodule

// File: tb/tb_load_reg_arbiter.sv
// Testbench for load_reg_arbiter. It starts with directed reset, latency, repeat and reset-in-CHECK cases.
// It then runs randomized rounds with scripted readback failures. A scoreboard monitor checks every load and every response.
module tb_load_reg_arbiter;
  localparam int N         = 4;
  localparam int W         = 4;
  localparam int MAX_RETRY = 2;

  typedef struct {
    int         idx;
    logic [W-1:0] word;
    bit         is_ack;
    int         loads;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  load_reg_arbiter_if #(.N(N), .W(W)) bus ();

  load_reg_arbiter #(.N(N), .W(W), .MAX_RETRY(MAX_RETRY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total  = 0;
  int   passed = 0;
  exp_t sb[$];
  logic mon_en = 1'b0;
  logic err_m  = 1'b0;
  int   ptr_m  = 0;
  bit   abort  = 1'b0;

  logic [W-1:0] cur_words [N];
  int           fail_plan [N];
  int           round_id = 0;

  // The shared register as the environment sees it. A scripted number of readbacks per requester come back inverted.
  logic [W-1:0] reg_q      = '0;
  logic         corrupt_q  = 1'b0;
  int           used [N]       = '{default: 0};
  int           used_round [N] = '{default: 0};

  always @(posedge clk) begin
    if (bus.load) begin
      reg_q     <= bus.I;
      corrupt_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        if (bus.I == cur_words[i]) begin
          corrupt_q     <= (((used_round[i] == round_id) ? used[i] : 0) < fail_plan[i]);
          used[i]       <= ((used_round[i] == round_id) ? used[i] : 0) + 1;
          used_round[i] <= round_id;
        end
      end
    end
  end

  assign bus.A = corrupt_q ? ~reg_q : reg_q;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [N*W-1:0] packWords();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) d[i*W +: W] = cur_words[i];
    return d;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] r);
    bus.req  = r;
    bus.data = packWords();
  endtask

  task automatic waitResponse(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while ((bus.ack | bus.nak) == '0 && cycles < budget);
    if ((bus.ack | bus.nak) == '0) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: each observed load and each response is compared against the head of the queue.
  int   loads_seen = 0;
  int   busy_cyc   = 0;
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] vec;
    if (mon_en) begin
      if (bus.busy) busy_cyc++;
      if (bus.load) begin
        loads_seen++;
        if (sb.size() == 0) checkOutput("unexpected_load", 32'd1, 32'd0);
        else checkOutput("load_word", bus.I, sb[0].word);
      end
      if ((bus.ack | bus.nak) != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e   = sb.pop_front();
          vec = N'(1) << e.idx;
          checkOutput("ack_vec", bus.ack, e.is_ack ? vec : '0);
          checkOutput("nak_vec", bus.nak, e.is_ack ? '0 : vec);
          checkOutput("load_count", loads_seen, e.loads);
          checkOutput("busy_cycles", busy_cyc, 2 * e.loads);
          if (e.is_ack) checkOutput("err_sticky", bus.err, err_m);
          else err_m = 1'b1;
        end
        loads_seen = 0;
        busy_cyc   = 0;
      end
    end
  end

  task automatic runRound();
    logic [N-1:0]     s;
    logic [2**W-1:0]  taken;
    logic [W-1:0]     w;
    int               last;
    int               i;
    s     = N'($urandom_range(1, 2**N - 1));
    taken = '0;
    for (int k = 0; k < N; k++) begin
      do w = W'($urandom_range(0, 2**W - 1)); while (taken[w]);
      taken[w]      = 1'b1;
      cur_words[k]  = w;
      fail_plan[k]  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, MAX_RETRY + 1);
    end
    round_id++;
    last = ptr_m;
    for (int k = 0; k < N; k++) begin
      i = (ptr_m + k) % N;
      if (s[i]) begin
        sb.push_back('{idx: i, word: cur_words[i], is_ack: (fail_plan[i] <= MAX_RETRY),
                       loads: (fail_plan[i] <= MAX_RETRY) ? fail_plan[i] + 1 : MAX_RETRY + 1});
        last = i;
      end
    end
    ptr_m = (last + 1) % N;
    applyStimulus(s);
    for (int cyc = 0; cyc < 300 && bus.req != '0; cyc++) begin
      @(negedge clk);
      #1;
      bus.req = bus.req & ~(bus.ack | bus.nak);
    end
    if (bus.req != '0) begin
      checkOutput("round_timeout", bus.req, 32'd0);
      abort = 1'b1;
    end else begin
      checkOutput("queue_drain", sb.size(), 32'd0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    int c;
    cur_words = '{4'h3, 4'h5, 4'hA, 4'hC};
    fail_plan = '{default: 0};

    rst = 1'b1;
    applyStimulus('1);
    repeat (2) @(negedge clk);
    checkOutput("rst_load", bus.load, 32'd0);
    checkOutput("rst_ack", bus.ack, 32'd0);
    checkOutput("rst_nak", bus.nak, 32'd0);
    checkOutput("rst_busy", bus.busy, 32'd0);
    checkOutput("rst_err", bus.err, 32'd0);
    applyStimulus('0);
    rst = 1'b0;
    @(negedge clk);

    // Clean write from requester 2: load at t+1, ack at t+2, idle again at t+3.
    applyStimulus(4'b0100);
    @(negedge clk);
    checkOutput("t1_load", bus.load, 32'd1);
    checkOutput("t1_I", bus.I, 32'hA);
    checkOutput("t1_ack", bus.ack, 32'd0);
    @(negedge clk);
    checkOutput("t2_ack", bus.ack, 32'b0100);
    checkOutput("t2_busy", bus.busy, 32'd1);
    applyStimulus('0);
    @(negedge clk);
    checkOutput("t3_busy", bus.busy, 32'd0);
    checkOutput("t3_load", bus.load, 32'd0);

    // A single requester that holds req is served again every 3 cycles.
    applyStimulus(4'b0100);
    waitResponse(10, c);
    checkOutput("repeat_first_latency", c, 32'd2);
    waitResponse(10, c);
    checkOutput("repeat_period", c, 32'd3);
    checkOutput("repeat_ack", bus.ack, 32'b0100);
    applyStimulus('0);
    @(negedge clk);

    // Reset during a matching CHECK: there is no ack and ptr returns to 0.
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("r6_load", bus.load, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus('0);
    #1;
    checkOutput("r6_in_check", bus.busy, 32'd1);
    checkOutput("r6_no_ack", bus.ack, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("r6_idle", bus.busy, 32'd0);
    checkOutput("r6_err", bus.err, 32'd0);
    applyStimulus(4'b1111);
    waitResponse(10, c);
    checkOutput("r6_ptr_grant", bus.ack, 32'b0001);
    applyStimulus('0);
    @(negedge clk);

    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    ptr_m  = 0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 30 && !abort; r++) runRound();

    @(negedge clk);
    checkOutput("final_err", bus.err, err_m);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
